// File: rtl/port_bus_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : port_bus_initiator_if
//  Purpose  : Bundles the command, response and RAT port bus signals of the
//             port bus initiator.
//  Ports    : cmd_valid/cmd_ready/cmd_wr/cmd_port/cmd_data  command channel
//             rsp_valid/rsp_data/rsp_port                   read responses
//             port_id/out_port/io_strb/in_port              RAT port bus
//             busy                                          activity flag
//  Modports : master - the initiator itself
//             slave  - the command source, response sink and peripheral mux
//  Revision : 1.0  initial release
// ============================================================================
interface port_bus_initiator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_port;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [7:0] rsp_port;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] in_port;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_wr, cmd_port, cmd_data, in_port,
    output cmd_ready, rsp_valid, rsp_data, rsp_port,
           port_id, out_port, io_strb, busy
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_port, cmd_data, in_port,
    input  cmd_ready, rsp_valid, rsp_data, rsp_port,
           port_id, out_port, io_strb, busy
  );
endinterface
`default_nettype wire

// File: rtl/port_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : port_bus_initiator
//  Purpose  : Drives the RAT port bus (PORT_ID, OUT_PORT, IO_STRB) and samples
//             IN_PORT the way the MCU does for OUT/IN, from commands queued in
//             a small FIFO. Read data returns on a one-cycle response pulse.
//  Params   : FIFO_DEPTH - command FIFO entries (power of two, >= 2)
//             RD_WAIT    - extra cycles PORT_ID is held before IN_PORT is
//                          sampled (0..15)
//  Ports    : clk     - system clock, rising edge
//             reset_n - synchronous active-low reset
//             bus     - command/response/port bus bundle (master modport)
//  Revision : 1.0  initial release
// ============================================================================
module port_bus_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_WAIT    = 0
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  port_bus_initiator_if.master   bus
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full     = c_cw'(FIFO_DEPTH);
  localparam logic [3:0]      c_rd_wait  = 4'(RD_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] port;
    logic [7:0] data;
  } cmd_t;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  cmd_t            fifo_mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0] count_q,  count_d;

  // --------------------------------------------------------------------------
  // Sequencer state and registered bus/response outputs
  // --------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [3:0] wait_q,      wait_d;
  logic [7:0] port_id_q,   port_id_d;
  logic [7:0] out_port_q,  out_port_d;
  logic       io_strb_q,   io_strb_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q,  rsp_data_d;
  logic [7:0] rsp_port_q,  rsp_port_d;

  logic w_ready;
  logic w_push;
  logic w_pop;
  cmd_t w_head;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even in a cycle where the sequencer is popping.
  assign w_ready = (count_q != c_full);
  assign w_push  = bus.cmd_valid & w_ready & reset_n;
  assign w_pop   = (state_q == ST_IDLE) && (count_q != '0);
  assign w_head  = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    port_id_d   = port_id_q;
    out_port_d  = out_port_q;
    rsp_data_d  = rsp_data_q;
    rsp_port_d  = rsp_port_q;
    // Strobe and response are single-cycle pulses unless set below.
    io_strb_d   = 1'b0;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (w_pop) begin
          port_id_d = w_head.port;
          if (w_head.wr) begin
            out_port_d = w_head.data;
            io_strb_d  = 1'b1;
            state_d    = ST_WRITE;
          end else begin
            wait_d  = c_rd_wait;
            state_d = ST_READ;
          end
        end
      end

      ST_WRITE: begin
        // The strobe was high for the cycle just ending; back to IDLE leaves a
        // gap cycle before the next command's strobe.
        state_d = ST_IDLE;
      end

      ST_READ: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          rsp_data_d  = bus.in_port;
          rsp_port_d  = port_id_q;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      wait_q      <= 4'd0;
      port_id_q   <= 8'h00;
      out_port_q  <= 8'h00;
      io_strb_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_port_q  <= 8'h00;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wait_q      <= wait_d;
      port_id_q   <= port_id_d;
      out_port_q  <= out_port_d;
      io_strb_q   <= io_strb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_port_q  <= rsp_port_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q] <= '{wr: bus.cmd_wr, port: bus.cmd_port, data: bus.cmd_data};
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.port_id   = port_id_q;
  assign bus.out_port  = out_port_q;
  assign bus.io_strb   = io_strb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_port  = rsp_port_q;
  assign bus.busy      = (state_q != ST_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_port_bus_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_port_bus_initiator
//  Purpose  : Directed self-checking bench for port_bus_initiator. Three
//             instances cover RD_WAIT = 0, 3 and 5 with a shared clock/reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_port_bus_initiator;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   seen;

  always #5 clk = ~clk;

  port_bus_initiator_if bus_a ();
  port_bus_initiator_if bus_b ();
  port_bus_initiator_if bus_c ();

  // Peripheral mux model: SWITCHES at 0x20 return 0x3C, everything else 0x00.
  assign bus_a.in_port = (bus_a.port_id == 8'h20) ? 8'h3C : 8'h00;
  assign bus_b.in_port = (bus_b.port_id == 8'h20) ? 8'h3C : 8'h00;
  assign bus_c.in_port = (bus_c.port_id == 8'h20) ? 8'h3C : 8'h00;

  port_bus_initiator #(.FIFO_DEPTH(4), .RD_WAIT(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );
  port_bus_initiator #(.FIFO_DEPTH(4), .RD_WAIT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );
  port_bus_initiator #(.FIFO_DEPTH(4), .RD_WAIT(5)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(bus_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic v, input logic wr, input logic [7:0] p, input logic [7:0] d);
    bus_a.cmd_valid = v; bus_a.cmd_wr = wr; bus_a.cmd_port = p; bus_a.cmd_data = d;
  endtask

  task automatic set_b(input logic v, input logic wr, input logic [7:0] p, input logic [7:0] d);
    bus_b.cmd_valid = v; bus_b.cmd_wr = wr; bus_b.cmd_port = p; bus_b.cmd_data = d;
  endtask

  task automatic set_c(input logic v, input logic wr, input logic [7:0] p, input logic [7:0] d);
    bus_c.cmd_valid = v; bus_c.cmd_wr = wr; bus_c.cmd_port = p; bus_c.cmd_data = d;
  endtask

  initial begin
    // ---------------- reset, with a push offered during reset --------------
    reset_n = 1'b0;
    set_a(1'b1, 1'b1, 8'h40, 8'h11);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    set_c(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_port_id",   bus_a.port_id,   8'h00);
    check("rst_out_port",  bus_a.out_port,  8'h00);
    check("rst_io_strb",   8'(bus_a.io_strb),   8'h0);
    check("rst_rsp_valid", 8'(bus_a.rsp_valid), 8'h0);
    check("rst_rsp_data",  bus_a.rsp_data,  8'h00);
    check("rst_rsp_port",  bus_a.rsp_port,  8'h00);
    check("rst_busy",      8'(bus_a.busy),      8'h0);
    check("rst_cmd_ready", 8'(bus_a.cmd_ready), 8'h1);
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    reset_n = 1'b1;
    tick();
    check("rst_push_ignored", 8'(bus_a.busy), 8'h0);
    check("rst_strb_after",   8'(bus_a.io_strb), 8'h0);

    // ---------------- single write 0x40 <- 0xA5 -----------------------------
    set_a(1'b1, 1'b1, 8'h40, 8'hA5);
    tick();                                   // accepted
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    check("wr_no_strb_yet", 8'(bus_a.io_strb), 8'h0);
    check("wr_busy",        8'(bus_a.busy),    8'h1);
    tick();                                   // popped, strobe cycle
    check("wr_strb",     8'(bus_a.io_strb), 8'h1);
    check("wr_port_id",  bus_a.port_id,     8'h40);
    check("wr_out_port", bus_a.out_port,    8'hA5);
    check("wr_no_rsp",   8'(bus_a.rsp_valid), 8'h0);
    tick();
    check("wr_strb_end", 8'(bus_a.io_strb), 8'h0);
    check("wr_idle",     8'(bus_a.busy),    8'h0);
    check("wr_port_hold", bus_a.port_id,    8'h40);

    // ---------------- single read 0x20, RD_WAIT=0 ---------------------------
    set_a(1'b1, 1'b0, 8'h20, 8'h99);
    tick();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    tick();                                   // popped
    check("rd0_port_id",  bus_a.port_id,       8'h20);
    check("rd0_no_strb",  8'(bus_a.io_strb),   8'h0);
    check("rd0_no_rsp",   8'(bus_a.rsp_valid), 8'h0);
    check("rd0_out_keep", bus_a.out_port,      8'hA5);
    tick();                                   // sampled
    check("rd0_rsp_valid", 8'(bus_a.rsp_valid), 8'h1);
    check("rd0_rsp_data",  bus_a.rsp_data,      8'h3C);
    check("rd0_rsp_port",  bus_a.rsp_port,      8'h20);
    tick();
    check("rd0_rsp_pulse", 8'(bus_a.rsp_valid), 8'h0);
    check("rd0_idle",      8'(bus_a.busy),      8'h0);

    // ---------------- single read 0x20, RD_WAIT=3 ---------------------------
    set_b(1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
    tick();                                   // popped
    for (int i = 0; i < 3; i++) begin
      check("rd3_wait_no_rsp",  8'(bus_b.rsp_valid), 8'h0);
      check("rd3_wait_no_strb", 8'(bus_b.io_strb),   8'h0);
      tick();
    end
    check("rd3_last_wait_no_rsp", 8'(bus_b.rsp_valid), 8'h0);
    check("rd3_port_held",        bus_b.port_id,       8'h20);
    tick();                                   // sampled at pop + 4
    check("rd3_rsp_valid", 8'(bus_b.rsp_valid), 8'h1);
    check("rd3_rsp_data",  bus_b.rsp_data,      8'h3C);
    check("rd3_rsp_port",  bus_b.rsp_port,      8'h20);
    tick();
    check("rd3_rsp_pulse", 8'(bus_b.rsp_valid), 8'h0);
    check("rd3_idle",      8'(bus_b.busy),      8'h0);

    // ---------------- FIFO full behind a RD_WAIT=5 read ---------------------
    set_c(1'b1, 1'b0, 8'h20, 8'h00);
    tick();                                   // read pushed
    set_c(1'b1, 1'b1, 8'h40, 8'h01);
    tick();                                   // read popped, w1 pushed
    set_c(1'b1, 1'b1, 8'h81, 8'h02);
    tick();
    set_c(1'b1, 1'b1, 8'h40, 8'h03);
    tick();
    set_c(1'b1, 1'b1, 8'h81, 8'h04);
    tick();                                   // four writes queued
    check("full_ready_low", 8'(bus_c.cmd_ready), 8'h0);
    set_c(1'b1, 1'b1, 8'h40, 8'h05);
    tick();
    tick();
    tick();                                   // read sampled
    check("full_rd_rsp",   8'(bus_c.rsp_valid), 8'h1);
    check("full_rd_data",  bus_c.rsp_data,      8'h3C);
    check("full_still_full", 8'(bus_c.cmd_ready), 8'h0);
    check("full_rd_no_strb", 8'(bus_c.io_strb), 8'h0);
    tick();                                   // pop w1, push refused
    check("full_ready_back", 8'(bus_c.cmd_ready), 8'h1);
    check("full_w1_strb", 8'(bus_c.io_strb), 8'h1);
    check("full_w1_port", bus_c.port_id,     8'h40);
    check("full_w1_data", bus_c.out_port,    8'h01);
    tick();                                   // w5 accepted now
    set_c(1'b0, 1'b0, 8'h00, 8'h00);
    check("full_count_max4", 8'(bus_c.cmd_ready), 8'h0);
    check("full_gap1",       8'(bus_c.io_strb),   8'h0);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("full_strb", 8'(bus_c.io_strb), 8'h1);
      check("full_port", bus_c.port_id,     (i % 2 == 1) ? 8'h81 : 8'h40);
      check("full_data", bus_c.out_port,    8'(i + 1));
      tick();
      check("full_gap",  8'(bus_c.io_strb), 8'h0);
    end
    check("full_done_idle", 8'(bus_c.busy), 8'h0);

    // ---------------- mixed order: W 0x81/07, R 0x20, W 0x40/FF -------------
    set_a(1'b1, 1'b1, 8'h81, 8'h07);
    tick();
    set_a(1'b1, 1'b0, 8'h20, 8'h00);
    tick();                                   // first write strobes
    check("mix_w1_strb", 8'(bus_a.io_strb), 8'h1);
    check("mix_w1_port", bus_a.port_id,     8'h81);
    check("mix_w1_data", bus_a.out_port,    8'h07);
    set_a(1'b1, 1'b1, 8'h40, 8'hFF);
    tick();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    check("mix_gap", 8'(bus_a.io_strb), 8'h0);
    tick();                                   // read popped
    check("mix_rd_port", bus_a.port_id,     8'h20);
    check("mix_rd_strb", 8'(bus_a.io_strb), 8'h0);
    check("mix_rd_out",  bus_a.out_port,    8'h07);
    tick();
    check("mix_rsp_valid", 8'(bus_a.rsp_valid), 8'h1);
    check("mix_rsp_data",  bus_a.rsp_data,      8'h3C);
    check("mix_rsp_port",  bus_a.rsp_port,      8'h20);
    tick();                                   // second write strobes
    check("mix_w2_strb", 8'(bus_a.io_strb),   8'h1);
    check("mix_w2_port", bus_a.port_id,       8'h40);
    check("mix_w2_data", bus_a.out_port,      8'hFF);
    check("mix_w2_norsp", 8'(bus_a.rsp_valid), 8'h0);
    tick();
    check("mix_idle", 8'(bus_a.busy), 8'h0);

    // ---------------- reset in the middle of a RD_WAIT=5 read ---------------
    set_c(1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    set_c(1'b0, 1'b0, 8'h00, 8'h00);
    tick();                                   // popped
    tick();
    check("rr_busy_before", 8'(bus_c.busy), 8'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rr_busy_after",  8'(bus_c.busy),      8'h0);
    check("rr_ready_after", 8'(bus_c.cmd_ready), 8'h1);
    check("rr_port_reset",  bus_c.port_id,       8'h00);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_c.rsp_valid) seen++;
    end
    check("rr_no_rsp", 8'(seen), 8'h00);
    check("rr_idle",   8'(bus_c.busy), 8'h0);
    set_c(1'b1, 1'b1, 8'h40, 8'h5A);
    tick();
    set_c(1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    check("rr_wr_strb", 8'(bus_c.io_strb), 8'h1);
    check("rr_wr_port", bus_c.port_id,     8'h40);
    check("rr_wr_data", bus_c.out_port,    8'h5A);
    tick();
    check("rr_wr_end",  8'(bus_c.io_strb), 8'h0);
    check("rr_wr_idle", 8'(bus_c.busy),    8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
